run_ctrl: RTL
=============

# run_ctrl

Run-control sequencer that sits between the top-level run/reset pins and the Beta CPU datapath. It is the receiving end of the `runCPU`/`clk`/`reset` stimulus that drives the CPU. It synchronizes the asynchronous `runCPU` request and holds the PC in reset for a fixed window after reset release. It then gates all architectural state updates (PC, register file, memory writes) through `cpu_en` and stops the machine permanently on a decoder halt request.

## Interface
- `SYNC_STAGES`, 2, number of flip-flops in the `runCPU` synchronizer (≥2)
- `HOLD_CYCLES`, 4, cycles `pc_rst` stays asserted after reset deassertion (≥1)
- `CNT_W`, 32, width of the executed-cycle counter
- `clk`  input  1  single system clock, rising-edge
- `reset`  input  1  asynchronous, active-low reset; 0 = reset asserted
- `runCPU`  input  1  asynchronous run level; 1 = run, 0 = pause
- `halt_req`  input  1  from decoder, synchronous; current instruction is a halt/trap
- `step_req`  input  1  synchronous single-step pulse (present only with `RUN_CTRL_STEP_EN`)
- `cpu_en`  output  1  datapath commit enable for this cycle
- `pc_rst`  output  1  force PC to 0 at the next edge
- `running`  output  1  state is RUN or STEP
- `halted`  output  1  state is HALTED
- `cycle_count`  output  CNT_W  number of cycles with `cpu_en`=1, saturating

## Operation
- States: HOLD, IDLE, RUN, STEP, HALTED. Encoding is binary, in a registered state register. All outputs are Moore decodes of state, except `cycle_count`, which is registered.
- HOLD: `pc_rst`=1. A down-counter loads `HOLD_CYCLES` on reset. State goes to IDLE on the edge where the counter reaches 0.
- IDLE: `cpu_en`=0. If `run_s`=1, go to RUN. Else, if step is enabled and `step_req`=1, go to STEP.
- RUN: `cpu_en`=1. `halt_req`=1 takes priority and goes to HALTED. Else `run_s`=0 goes to IDLE (pause; PC is preserved).
- STEP: `cpu_en`=1 for exactly one cycle. `halt_req`=1 goes to HALTED, otherwise go to IDLE.
- HALTED: `cpu_en`=0. The state is sticky and is left only by `reset`. `runCPU` and `step_req` are ignored.
- `run_s` is the output of the `SYNC_STAGES`-deep synchronizer. It keeps running in every state. `runCPU` is ignored in HOLD (the sync value is not latched).
- `cycle_count` increments by 1 on each edge where `cpu_en`=1. It saturates at all-ones with no wrap.
- Reset values, while `reset`=0: state HOLD, hold counter = `HOLD_CYCLES`, sync flops 0, `cpu_en`=0, `pc_rst`=1, `running`=0, `halted`=0, `cycle_count`=0.
- Reset asserted mid-RUN clears all of the above asynchronously. The instruction in flight does not commit.

## Timing
- Reset release to IDLE: `HOLD_CYCLES` rising edges after `reset` goes high. `pc_rst` is high for exactly those cycles.
- `runCPU` rising, sampled stable at edge t0 (state IDLE):
  - `run_s`=1 after edge t0+SYNC_STAGES−1.
  - State RUN and `cpu_en`=1 after edge t0+SYNC_STAGES.
- `runCPU` falling: the same latency to IDLE. Cycles already enabled still commit.
- `halt_req` sampled high in RUN at edge t:
  - The halt instruction commits at edge t, because `cpu_en` was 1 in that cycle.
  - `cpu_en`=0 and `halted`=1 from t onward.
- Halt and pause in the same cycle: HALTED wins.
- Step in IDLE at edge t: `cpu_en`=1 during cycle t..t+1, then 0. A `step_req` held high re-steps every other cycle.

## Configuration
- `RUN_CTRL_STEP_EN` defined:
  - The `step_req` port and the STEP state exist.
  - `running` covers both RUN and STEP.
- `RUN_CTRL_STEP_EN` undefined:
  - There is no `step_req` port and no STEP state.
  - IDLE leaves only on `run_s`. All other behaviour is identical.

## Structure
- Shared package `beta_pkg`: state encodings `RC_HOLD`, `RC_IDLE`, `RC_RUN`, `RC_STEP`, `RC_HALTED`, plus the default `HOLD_CYCLES` constant.
- One sub-module: `sync_ff`, parameterised depth and width 1. It uses the same active-low asynchronous reset and resets to 0.
- The counter saturation and hold counter stay inline in `run_ctrl`.

## Test plan
- Reset low 2 cycles then high, `HOLD_CYCLES`=4 → `pc_rst`=1 for exactly 4 edges, state IDLE, all other outputs 0.
- `runCPU`=1 held after HOLD → `cpu_en` rises exactly SYNC_STAGES edges after first sample; `cycle_count`=10 after 10 enabled cycles.
- In RUN, pulse `halt_req` 1 cycle → count includes the halt cycle, then `halted`=1 and `cpu_en`=0 for 20+ cycles while `runCPU` toggles.
- `runCPU` 1→0→1 mid-run → IDLE for the pause duration with count frozen, then resume; `pc_rst` never reasserts.
- `CNT_W`=4, run 20 cycles → `cycle_count` sticks at 15.
- With `RUN_CTRL_STEP_EN`, three `step_req` pulses in IDLE → exactly 3 `cpu_en` cycles, `cycle_count`=3; reset asserted during RUN → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/beta_pkg.sv
// beta_pkg: definitions shared by the Beta CPU run-control logic.
//   rcState_t       - encoding of the run_ctrl sequencer states (binary, 3 bits)
//   HOLD_CYCLES_DEF - default number of cycles the PC is held in reset
package beta_pkg;

    typedef enum logic [2:0] {
        RC_HOLD   = 3'd0,
        RC_IDLE   = 3'd1,
        RC_RUN    = 3'd2,
        RC_STEP   = 3'd3,
        RC_HALTED = 3'd4
    } rcState_t;

    localparam int HOLD_CYCLES_DEF = 4;

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: run-control signals between the pins/decoder side and run_ctrl.
//   runCPU      - asynchronous run level (1 = run)
//   halt_req    - decoder halt/trap request, synchronous
//   step_req    - single-step pulse (only when RUN_CTRL_STEP_EN is defined)
//   cpu_en      - datapath commit enable
//   pc_rst      - force PC to 0 at the next edge
//   running     - sequencer is executing (RUN or STEP)
//   halted      - sequencer is halted
//   cycle_count - saturating count of enabled cycles
// Modports: master drives the requests, slave (run_ctrl) drives the status.
// Optional feature macro: RUN_CTRL_STEP_EN.
interface run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             runCPU;
    logic             halt_req;
`ifdef RUN_CTRL_STEP_EN
    logic             step_req;
`endif
    logic             cpu_en;
    logic             pc_rst;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

`ifdef RUN_CTRL_STEP_EN
    modport master (
        output runCPU, halt_req, step_req,
        input  cpu_en, pc_rst, running, halted, cycle_count
    );
    modport slave (
        input  runCPU, halt_req, step_req,
        output cpu_en, pc_rst, running, halted, cycle_count
    );
`else
    modport master (
        output runCPU, halt_req,
        input  cpu_en, pc_rst, running, halted, cycle_count
    );
    modport slave (
        input  runCPU, halt_req,
        output cpu_en, pc_rst, running, halted, cycle_count
    );
`endif

endinterface

// File: rtl/sync_ff.sv
// sync_ff: DEPTH-stage flip-flop synchronizer for an asynchronous input.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, all stages clear to 0
//   d     - asynchronous input
//   q     - synchronized output (DEPTH cycles of latency)
module sync_ff #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run-control sequencer for the Beta CPU datapath.
// Synchronizes runCPU, holds the PC in reset for HOLD_CYCLES cycles after
// reset release, gates architectural updates through cpu_en and stops
// permanently on a decoder halt request.
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset (0 = in reset)
//   bus   - run_ctrl_if slave: runCPU, halt_req, [step_req] in;
//           cpu_en, pc_rst, running, halted, cycle_count out
// Optional feature macro: RUN_CTRL_STEP_EN adds step_req and the STEP state.
module run_ctrl
    import beta_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    run_ctrl_if.slave   bus
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    rcState_t         state;
    rcState_t         stateNext;
    logic [HC_W-1:0]  holdCnt;
    logic [CNT_W-1:0] cycleCnt;
    logic             runS;
    logic             cpuEn;
    logic             pcRst;
    logic             runningO;
    logic             haltedO;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The synchronizer runs in every state; HOLD simply ignores its output.
    sync_ff #(
        .DEPTH (SYNC_STAGES),
        .WIDTH (1)
    ) uRunSync (
        .clk   (clk),
        .rst_n (reset),
        .d     (bus.runCPU),
        .q     (runS)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RC_HOLD;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdCnt <= HC_W'(HOLD_CYCLES);
        end else if (state == RC_HOLD && holdCnt != '0) begin
            holdCnt <= holdCnt - HC_W'(1);
        end
    end

    // HOLD leaves on the edge where the counter steps from 1 to 0.
    always_comb begin
        stateNext = state;
        unique case (state)
            RC_HOLD: begin
                if (holdCnt == HC_W'(1)) begin
                    stateNext = RC_IDLE;
                end
            end
            RC_IDLE: begin
                if (runS) begin
                    stateNext = RC_RUN;
                end
`ifdef RUN_CTRL_STEP_EN
                else if (bus.step_req) begin
                    stateNext = RC_STEP;
                end
`endif
            end
            RC_RUN: begin
                if (bus.halt_req) begin
                    stateNext = RC_HALTED;
                end else if (!runS) begin
                    stateNext = RC_IDLE;
                end
            end
`ifdef RUN_CTRL_STEP_EN
            RC_STEP: begin
                stateNext = bus.halt_req ? RC_HALTED : RC_IDLE;
            end
`endif
            RC_HALTED: begin
                stateNext = RC_HALTED;
            end
            default: begin
                stateNext = RC_HOLD;
            end
        endcase
    end

    always_comb begin
        cpuEn    = 1'b0;
        pcRst    = 1'b0;
        runningO = 1'b0;
        haltedO  = 1'b0;
        unique case (state)
            RC_HOLD:   pcRst = 1'b1;
            RC_RUN: begin
                cpuEn    = 1'b1;
                runningO = 1'b1;
            end
`ifdef RUN_CTRL_STEP_EN
            RC_STEP: begin
                cpuEn    = 1'b1;
                runningO = 1'b1;
            end
`endif
            RC_HALTED: haltedO = 1'b1;
            default: begin
                cpuEn = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleCnt <= '0;
        end else if (cpuEn) begin
            cycleCnt <= satInc(cycleCnt);
        end
    end

    assign bus.cpu_en      = cpuEn;
    assign bus.pc_rst      = pcRst;
    assign bus.running     = runningO;
    assign bus.halted      = haltedO;
    assign bus.cycle_count = cycleCnt;

endmodule
